// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the ALU-decoder funct values that route instructions to this unit.
package muldiv_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on a {upper, lower} 2*WIDTH accumulator. Purely combinational.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;

    always_comb begin
        addend  = acc_i[0] ? opnd_i : '0;
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        part    = acc_i[2*WIDTH-1:WIDTH-1];
        diff    = part[WIDTH-1:0] - opnd_i;
        q_bit_o = 1'b0;
        acc_o   = {sum, acc_i[WIDTH-1:1]};
        if (div_mode_i) begin
            // part is the shifted partial remainder; a zero divisor always
            // subtracts, which leaves the dividend in the upper half at the end.
            q_bit_o = (part >= {1'b0, opnd_i});
            // Bit 0 is left clear here; the caller inserts the quotient bit.
            acc_o   = q_bit_o ? {diff, acc_i[WIDTH-2:0], 1'b0}
                              : {acc_i[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// IDLE -> RUN (WIDTH iterations) -> FIX (sign correction, HI/LO write, done).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               bzero_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               q_bit;

    logic               is_signed;
    logic               is_div;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        sa        = is_signed & srca[WIDTH-1];
        sb        = is_signed & srcb[WIDTH-1];
        mag_a     = sa ? -srca : srca;
        mag_b     = sb ? -srcb : srcb;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode_i (div_q),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (acc_step),
        .q_bit_o    (q_bit)
    );

    assign acc_d = acc_step | {{(2*WIDTH-1){1'b0}}, q_bit};

    // Sign fix. Remainder sign follows the dividend, so a zero divisor
    // restores the original srca in HI while LO stays all ones.
    always_comb begin
        prod_fix = qneg_q ? -acc_q : acc_q;
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (div_q) begin
            hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_d = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            if (bzero_q) begin
                lo_d = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        div_q   <= is_div;
                        qneg_q  <= sa ^ sb;
                        rneg_q  <= sa;
                        bzero_q <= (srcb == '0);
                        acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                        opnd_q  <= is_div ? mag_b : mag_a;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    dbz_q   <= div_q & bzero_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes {div_by_zero,hi,lo}
// expectations, a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic [2*W:0] exp_q[$];
    int           checks;
    int           failures;
    logic [W-1:0] cur_hi;
    logic [W-1:0] cur_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .srca        (srca),
        .srcb        (srcb),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural definitions.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint        sa;
        longint        sb;
        logic [63:0]   p;
        logic [63:0]   q;
        logic [63:0]   r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%h required=none", {div_by_zero, hi, lo});
            end else begin
                check("result", {div_by_zero, hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Driver: called at a negedge; mode 0 plain, 1 re-pulse start while busy,
    // 2 mtlo while busy. Returns at the negedge where done is seen.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        logic [2*W:0] e;
        int           k;
        int           busy_cycles;
        bit           got;
        e = model(o, a, b);
        exp_q.push_back(e);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        k = 0;
        busy_cycles = 0;
        got = 0;
        while (k < 200 && !got) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            lo_we = 1'b0;
            op    = 2'($urandom_range(0, 3));
            srca  = $urandom;
            srcb  = $urandom;
            if (mode == 1 && k == 5) start = 1'b1;
            if (mode == 2 && k == 3) begin
                lo_we = 1'b1;
                wdata = 32'h1234;
            end
            if (mode == 2 && k == 4) check("mtlo_busy_lo", {33'b0, lo}, {33'b0, cur_lo});
            if (done) begin
                got = 1;
                check("busy_low_at_done", {64'b0, busy}, '0);
            end else if (busy) begin
                busy_cycles++;
            end
        end
        start = 1'b0;
        lo_we = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d required=%0d", k, W + 2);
        end else begin
            check("latency", 65'(k), 65'(W + 2));
            check("busy_cycles", 65'(busy_cycles), 65'(W + 1));
        end
        cur_hi = e[2*W-1:W];
        cur_lo = e[W-1:0];
    endtask

    initial begin
        int n_seen;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks = 0;
        failures = 0;
        start = 0; op = 0; srca = 0; srcb = 0;
        hi_we = 0; lo_we = 0; wdata = 0;
        cur_hi = 0; cur_lo = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_state", {busy, done, div_by_zero, hi, lo}, '0);

        @(negedge clk);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op(2'b00, 32'hFFFFFFF9, 32'd3, 0);
        do_op(2'b00, 32'h80000000, 32'h80000000, 0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        do_op(2'b11, 32'd100, 32'd7, 0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        do_op(2'b11, 32'd5, 32'd0, 0);
        check("dbz_sticky", {64'b0, div_by_zero}, 65'd1);
        do_op(2'b01, 32'd2, 32'd3, 0);
        do_op(2'b10, 32'hFFFFFF00, 32'd0, 0);
        do_op(2'b00, 32'd12345, 32'hFFFF0000, 1);
        do_op(2'b01, 32'd77, 32'd11, 2);

        // mthi/mtlo in IDLE
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", {1'b0, hi, lo}, {1'b0, cur_hi, 32'h1234});
        cur_lo = 32'h1234;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFEF00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo_both", {1'b0, hi, lo}, {1'b0, 32'hCAFEF00D, 32'hCAFEF00D});
        cur_hi = 32'hCAFEF00D;
        cur_lo = 32'hCAFEF00D;

        // Randomized operations, back-to-back
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, 0);
        end

        // Asynchronous reset mid-DIV
        start = 1'b1;
        op    = 2'b10;
        srca  = 32'hFFFF1234;
        srcb  = 32'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", {busy, done, div_by_zero, hi, lo}, '0);
        @(negedge clk);
        reset = 1'b0;
        cur_hi = 0;
        cur_lo = 0;
        n_seen = 0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge clk);
            if (done) n_seen++;
        end
        check("no_done_after_abort", 65'(n_seen), '0);
        do_op(2'b11, 32'd1000, 32'd33, 0);

        @(negedge clk);
        check("scoreboard_drained", 65'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit with architectural HI/LO registers; executes MULT, MULTU, DIV and DIVU.
- Sits beside the ALU in the datapath and completes the mult/div/mfhi/mflo functions that the ALU decoder already encodes.
- The controller pulses start, stalls on busy for mfhi/mflo/mthi/mtlo, and reads HI/LO directly.
- Radix-2 iterative: one product or quotient bit per cycle, followed by one sign-fix cycle.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Legal range is 4..64.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with start.
- srca  in  WIDTH  rs operand: multiplicand or dividend. Sampled with start.
- srcb  in  WIDTH  rt operand: multiplier or divisor. Sampled with start.
- hi_we  in  1  mthi write strobe.
- lo_we  in  1  mtlo write strobe.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  operation in progress; controller must stall HI/LO consumers.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  sticky flag; set by DIV/DIVU with srcb=0, cleared by the next accepted start.
- hi  out  WIDTH  HI register (mfhi).
- lo  out  WIDTH  LO register (mflo).

Behaviour:
- Reset (async, any state): state goes to IDLE; busy, done, div_by_zero, hi, lo, counter and all working registers go to 0.
- States: IDLE -> RUN -> FIX -> IDLE.
  - IDLE: start=1 latches op, the operand magnitudes and the result sign bits, and loads counter=WIDTH. Next state is RUN.
  - RUN: one iteration per cycle with counter-- each cycle; exit to FIX when the counter reaches 0, i.e. after WIDTH cycles.
  - FIX: apply sign correction, write hi and lo, and pulse done on the same edge; then return to IDLE.
- Timing: if start is sampled at edge E0, hi/lo update and done goes high at edge E0+WIDTH+1. busy is high from E0 until E0+WIDTH+1 and low while done=1. Back-to-back start is accepted in the done cycle.
- Signed ops (MULT, DIV) operate on magnitudes, where |x| is the unsigned WIDTH-bit two's-complement negation if x<0.
  - MULT sign = sa^sb.
  - DIV quotient sign = sa^sb; remainder sign = sa.
  - Unsigned ops skip correction.
- Multiply: shift-add into a 2*WIDTH accumulator. Result {hi,lo} is the full 2*WIDTH product.
- Divide: restoring algorithm. lo = quotient, hi = remainder.
- Divide by zero: the iteration still runs the full latency. Result is hi=srca (unchanged) and lo=all ones, with no sign fix. div_by_zero is set at the done edge.
- Overflow case DIV of most-negative by -1: the natural magnitude path gives lo=100..0 and hi=0. No flag is raised.
- start while busy is ignored; no queuing. op/srca/srcb changes while busy have no effect.
- mthi/mtlo:
  - hi_we/lo_we write wdata on the clock edge only when the state is IDLE and start=0.
  - When asserted together with an accepted start, or while busy, the write is dropped.
  - The controller stalls these instructions via busy.
  - hi_we and lo_we together write both registers.
- hi/lo are stable and readable in all states. During RUN they show the previous result; the working accumulator is internal.
- Reset mid-operation aborts the operation; no done pulse is produced.

Decomposition:
- Shared package: op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11), state encodings (IDLE, RUN, FIX), and the ALU-decoder funct constants (MULT 011000, DIV 011010, MFHI 010000, MFLO 010010, plus MULTU 011001 and DIVU 011011).
- One natural sub-module, muldiv_step: a combinational single iteration. Given mode, accumulator and operand it returns the next accumulator and quotient bit. The top level holds the FSM, counter, sign fix and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at E0+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1. Next MULTU 2*3 clears div_by_zero: lo=6, hi=0.
- start re-pulsed at E0+5 with different operands -> ignored; result matches the first op. mtlo 0x1234 asserted during busy -> lo unchanged; mtlo 0x1234 in IDLE -> lo=0x1234 next cycle.
- reset asserted asynchronously at E0+10 of a DIV -> busy, done, hi, lo = 0 immediately; no done pulse. A new start afterwards completes normally.
